// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the ripple-carry adder and the bit-serial subtractor.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = arith_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: D = A - B - Bin, with borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  logic a_xnor_b;

  assign a_xnor_b = ~(A ^ B);
  assign D        = A ^ B ^ Bin;
  assign Bout     = (~A & B) | (a_xnor_b & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  sub_state_e       state_q;
  sub_state_e       state_d;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rs_nxt;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             bo;
  logic             last_bit;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  full_subtractor u_cell (
    .A   (ra[0]),
    .B   (rb[0]),
    .Bin (br),
    .D   (d),
    .Bout(bo)
  );

  assign last_bit = (cnt == LAST);
  // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign rs_nxt   = WIDTH'({d, rs} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      rs     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ra  <= bus.a;
            rb  <= bus.b;
            br  <= bus.bin;
            cnt <= '0;
          end
        end
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rs  <= rs_nxt;
          br  <= bo;
          cnt <= cnt + CNT_W'(1);
          // Signed overflow: borrow into the MSB differs from borrow out of it.
          if (last_bit) begin
            diff_q <= rs_nxt;
            bout_q <= bo;
            ovf_q  <= br ^ bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule
